display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000000: minimum clk cycles an owner keeps the display while the other requester waits (1 s at 50 MHz); legal range 2..2^26.
REQ-002 Parameter CW, default 26: width of the dwell counter; CW SHALL hold DWELL_CYCLES-1.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_a  in  1  requester A wants the display; level, held while it wants ownership.
REQ-006 data_a  in  16  requester A value, four BCD/hex nibbles.
REQ-007 req_b  in  1  requester B wants the display.
REQ-008 data_b  in  16  requester B value.
REQ-009 gnt_a  out  1  A currently owns the display.
REQ-010 gnt_b  out  1  B currently owns the display.
REQ-011 num  out  16  value for the 4-digit multiplexed display driver.
REQ-012 blank  out  1  high when nobody owns the display; the driver turns all anodes off.

Function
REQ-013 FSM states: IDLE, OWN_A, OWN_B; all outputs registered.
REQ-014 gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B; never both high.
REQ-015 IDLE: num=16'h0000, blank=1.
REQ-016 OWN_x: num=data_x, sampled every cycle, 1-cycle latency; blank=0.
REQ-017 IDLE->OWN_x: one cycle after req_x is sampled high.
REQ-018 Both requests high in IDLE: round-robin; winner is the requester other than last_owner.
REQ-019 last_owner register updates on every grant.
REQ-020 dwell_cnt clears to 0 on every grant/switch, increments each owned cycle, saturates at DWELL_CYCLES-1.
REQ-021 Expired = dwell_cnt==DWELL_CYCLES-1.
REQ-022 Owner request low: release next cycle, regardless of dwell; go to the other owner if it requests, else IDLE.
REQ-023 Owner request high, other high, expired: switch to the other owner next cycle.
REQ-024 Owner request high, other low: keep ownership indefinitely; counter stays saturated.
REQ-025 Other request raised after expiry: switch one cycle later.
REQ-026 Request pulses shorter than one cycle are not captured.

Reset
REQ-027 rst=1 SHALL force IDLE, gnt_a=0, gnt_b=0, num=16'h0000, blank=1, dwell_cnt=0, last_owner=B so A wins the first tie.
REQ-028 rst asserted mid-ownership SHALL drop the grant on the next edge; arbitration restarts from IDLE once rst=0.

Configuration
REQ-029 Macro DISP_ARB_FIXED_PRIO_EN: when defined, A has fixed priority.
  - A wins every tie.
  - B is preempted once B's dwell has expired and A requests.
  - B never preempts A; A holds until req_a drops.
  - last_owner is unused.
REQ-030 When DISP_ARB_FIXED_PRIO_EN is undefined, arbitration is round-robin per REQ-018 to REQ-025.

Verification (DWELL_CYCLES=8)
REQ-031 Reset: rst=1 for 3 cycles with both requests high -> gnt_a=gnt_b=0, blank=1, num=0000; first grant is A, 1 cycle after rst falls.
REQ-032 Solo owner: req_a high, data_a=16'h1234 -> gnt_a=1 and num=1234 one cycle later; data_a=16'h5678 -> num=5678 one cycle later; holds 100 cycles.
REQ-033 Contention: A owns, req_b raised at owned cycle 2 -> gnt_b after 8 owned cycles; then A regains after 8 B-owned cycles; alternates.
REQ-034 Early release: A owns 3 cycles, req_a drops with req_b high -> gnt_b next cycle, num=data_b.
REQ-035 Mid reset: rst pulsed for 1 cycle during OWN_B -> IDLE next edge; with both requesting, A is granted first after reset.
REQ-036 Fixed priority (macro defined), both requesting -> A owns indefinitely; req_a drops -> B owns; req_a rises -> A regains after B's 8 owned cycles.

Source files
------------

// File: rtl/display_arbiter.sv
// Two-requester arbiter for a shared 4-digit display with a minimum dwell per owner.
// Optional macro DISP_ARB_FIXED_PRIO_EN selects fixed A priority instead of round-robin.
module display_arbiter #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CW           = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [15:0] num,
    output logic        blank
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic [15:0]   num_q, num_d;
    logic          blank_q, blank_d;
    logic          expired;

    assign expired = (dwell_cnt_q == DWELL_MAX);

`ifdef DISP_ARB_FIXED_PRIO_EN
    // A wins ties and is never preempted; B yields to A once its dwell expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a)
                    state_d = OWN_A;
                else if (req_b)
                    state_d = OWN_B;
            end
            OWN_A: begin
                if (!req_a)
                    state_d = req_b ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (!req_b)
                    state_d = req_a ? OWN_A : IDLE;
                else if (req_a && expired)
                    state_d = OWN_A;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    // last_owner_q: 1 means B was granted most recently, so A wins the next tie.
    logic last_owner_q, last_owner_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b)
                    state_d = last_owner_q ? OWN_A : OWN_B;
                else if (req_a)
                    state_d = OWN_A;
                else if (req_b)
                    state_d = OWN_B;
            end
            OWN_A: begin
                if (!req_a)
                    state_d = req_b ? OWN_B : IDLE;
                else if (req_b && expired)
                    state_d = OWN_B;
            end
            OWN_B: begin
                if (!req_b)
                    state_d = req_a ? OWN_A : IDLE;
                else if (req_a && expired)
                    state_d = OWN_A;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_d == OWN_A && state_q != OWN_A)
            last_owner_d = 1'b0;
        else if (state_d == OWN_B && state_q != OWN_B)
            last_owner_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_owner_q <= 1'b1;
        else
            last_owner_q <= last_owner_d;
    end
`endif

    // Counter restarts on any change of owner and saturates at the expiry value.
    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if (state_d == IDLE || state_d != state_q)
            dwell_cnt_d = '0;
        else if (!expired)
            dwell_cnt_d = dwell_cnt_q + CW'(1);
    end

    // Outputs follow the next state so they are registered alongside it.
    always_comb begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        num_d   = 16'h0000;
        blank_d = 1'b1;
        case (state_d)
            OWN_A: begin
                gnt_a_d = 1'b1;
                num_d   = data_a;
                blank_d = 1'b0;
            end
            OWN_B: begin
                gnt_b_d = 1'b1;
                num_d   = data_b;
                blank_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dwell_cnt_q <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            num_q       <= 16'h0000;
            blank_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            num_q       <= num_d;
            blank_q     <= blank_d;
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign num   = num_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios plus randomized traffic against an
// owner/dwell reference model; honours DISP_ARB_FIXED_PRIO_EN when defined.
module tb_display_arbiter;

    localparam int DWELL = 8;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] data_a = 16'h0000;
    logic [15:0] data_b = 16'h0000;
    logic        gnt_a, gnt_b, blank;
    logic [15:0] num;

    display_arbiter #(.DWELL_CYCLES(DWELL), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .num(num), .blank(blank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none 1=A 2=B; owned = cycles held so far, counting the current one.
    int m_owner = 0;
    int m_owned = 0;
    int m_last  = 2;
    int prev_owner = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int nxt, mine, other, other_req;
        logic own_req;
        nxt = m_owner;
        if (rst) begin
            m_owner = 0;
            m_owned = 0;
            m_last  = 2;
            return;
        end
        if (m_owner == 0) begin
`ifdef DISP_ARB_FIXED_PRIO_EN
            if (req_a) nxt = 1; else if (req_b) nxt = 2;
`else
            if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
            else if (req_a) nxt = 1;
            else if (req_b) nxt = 2;
`endif
        end else begin
            mine      = m_owner;
            other     = 3 - mine;
            own_req   = (mine == 1) ? req_a : req_b;
            other_req = (other == 1) ? int'(req_a) : int'(req_b);
            if (!own_req)
                nxt = other_req ? other : 0;
            else if (other_req != 0 && m_owned >= DWELL) begin
`ifdef DISP_ARB_FIXED_PRIO_EN
                if (mine == 2) nxt = other;
`else
                nxt = other;
`endif
            end
        end
        if (nxt == 0)
            m_owned = 0;
        else if (nxt != m_owner) begin
            m_owned = 1;
            m_last  = nxt;
        end else
            m_owned++;
        m_owner = nxt;
    endtask

    task automatic compare_all();
        logic [15:0] exp_num;
        exp_num = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : 16'h0000;
        check_eq("gnt_a", {31'b0, gnt_a}, {31'b0, m_owner == 1});
        check_eq("gnt_b", {31'b0, gnt_b}, {31'b0, m_owner == 2});
        check_eq("blank", {31'b0, blank}, {31'b0, m_owner == 0});
        check_eq("num",   {16'b0, num},   {16'b0, exp_num});
        check_eq("excl",  {31'b0, gnt_a & gnt_b}, 32'd0);
        if (m_owner != prev_owner)
            $display("t=%0t owner %0d -> %0d num=%h", $time, prev_owner, m_owner, num);
        prev_owner = m_owner;
    endtask

    // One clock: apply inputs, advance DUT and model on the edge, compare just after.
    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic [15:0] da, input logic [15:0] db);
        rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int n;

    initial begin
        // Reset with both requesting, then first grant goes to A
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
            check_eq("rst_gnt", {30'b0, gnt_a, gnt_b}, 32'd0);
            check_eq("rst_blank", {31'b0, blank}, 32'd1);
            check_eq("rst_num", {16'b0, num}, 32'h0000);
        end
        step(1'b0, 1'b1, 1'b1, 16'h1111, 16'h2222);
        check_eq("first_gnt_a", {31'b0, gnt_a}, 32'd1);

        // Solo owner follows data with one cycle latency
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0);
        check_eq("solo_1234", {15'b0, gnt_a, num}, 32'h0001_1234);
        step(1'b0, 1'b1, 1'b0, 16'h5678, 16'h0);
        check_eq("solo_5678", {16'b0, num}, 32'h5678);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 16'h5678, 16'h0);
        check_eq("solo_hold", {31'b0, gnt_a}, 32'd1);

`ifndef DISP_ARB_FIXED_PRIO_EN
        // Contention: each owner keeps the display for exactly DWELL cycles
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB);
        n = 1;
        step(1'b0, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB);
        n++;
        while (gnt_a && n < 50) begin
            step(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
            if (gnt_a) n++;
        end
        check_eq("a_dwell", n, DWELL);
        check_eq("b_after_a", {31'b0, gnt_b}, 32'd1);
        n = 1;
        while (gnt_b && n < 50) begin
            step(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
            if (gnt_b) n++;
        end
        check_eq("b_dwell", n, DWELL);
        check_eq("a_regains", {31'b0, gnt_a}, 32'd1);
`endif

        // Early release hands over the next cycle
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0A0A, 16'h0B0B);
        step(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B);
        check_eq("early_gnt_b", {15'b0, gnt_b, num}, 32'h0001_0B0B);

        // Mid-ownership reset drops B, then A wins the tie
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0B0B);
        step(1'b1, 1'b1, 1'b1, 16'h0A0A, 16'h0B0B);
        check_eq("midrst_drop", {30'b0, gnt_b, blank}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 16'h0A0A, 16'h0B0B);
        check_eq("midrst_a", {31'b0, gnt_a}, 32'd1);

`ifdef DISP_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1, 16'hA5A5, 16'hB5B5);
        check_eq("fp_a_holds", {31'b0, gnt_a}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 16'hA5A5, 16'hB5B5);
        check_eq("fp_b_owns", {31'b0, gnt_b}, 32'd1);
        n = 1;
        while (gnt_b && n < 50) begin
            step(1'b0, 1'b1, 1'b1, 16'hA5A5, 16'hB5B5);
            if (gnt_b) n++;
        end
        check_eq("fp_b_dwell", n, DWELL);
        check_eq("fp_a_regains", {31'b0, gnt_a}, 32'd1);
`endif

        // Randomized traffic: slowly changing request levels, random data, rare resets
        begin
            logic ra, rb, r;
            ra = 1'b0; rb = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 11) == 0) ra = ~ra;
                if ($urandom_range(0, 11) == 0) rb = ~rb;
                r = ($urandom_range(0, 299) == 0);
                step(r, ra, rb, 16'($urandom), 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
